// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr_pkg
//   Shared definitions for the round-robin / fixed-priority stream multiplexer.
//   Provides the arbitration mode constants and a clog2 helper used to size
//   the channel index (SEL_W) consistently in the interface, arbiter and top.
package stream_mux_rr_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Width needed to hold an index 0..value-1, never less than one bit so a
  // two-channel mux still gets a real select signal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
//   Bundles the producer-side and consumer-side handshakes of the multiplexer.
//   Ports (signals):
//     in_data   N_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//     in_valid  N_CH        per-channel valid
//     in_ready  N_CH        per-channel ready, one-hot or zero
//     out_data  WIDTH       registered output beat
//     out_sel   SEL_W       channel that supplied out_data
//     out_valid 1           output holds a beat
//     out_ready 1           consumer accepts the beat
//   Modports: slave = the multiplexer, master = the environment driving it.
interface stream_mux_rr_if
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) ();

  localparam int SEL_W = clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// stream_mux_rr_arbiter
//   Purely combinational arbiter producing a one-hot (or zero) grant.
//   Ports:
//     req    in   N_CH   request vector (channel valids)
//     last   in   SEL_W  index of the most recently served channel
//     grant  out  N_CH   one-hot grant, zero when nothing is requested
//   MODE_RR scans last+1, last+2, ... with wrap; MODE_FIXED picks the lowest
//   requesting index and ignores last.
module stream_mux_rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int MODE = MODE_RR
) (
  input  logic [N_CH-1:0]        req,
  input  logic [clog2(N_CH)-1:0] last,
  output logic [N_CH-1:0]        grant
);

  localparam int SEL_W = clog2(N_CH);

  logic             found;
  logic [SEL_W-1:0] idx;

  // The wrap uses an explicit compare against N_CH-1 rather than relying on
  // natural overflow, so channel counts that are not a power of two still
  // cycle through exactly N_CH positions.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = last;
    if (MODE == MODE_FIXED) begin
      for (int i = 0; i < N_CH; i++) begin
        if (req[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        idx = (idx == SEL_W'(N_CH - 1)) ? '0 : idx + 1'b1;
        if (req[idx] && !found) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-channel, WIDTH-bit streaming multiplexer with internal arbitration and a
//   registered output stage (one cycle from input transfer to out_valid).
//   Ports:
//     clk  in  1  rising-edge clock
//     rst  in  1  asynchronous active-high reset
//     bus  slave modport of stream_mux_rr_if (input channels + output stream)
//   Parameters: N_CH channels (2..16), WIDTH bits per beat, MODE 0 = round
//   robin, 1 = fixed priority with lowest index winning.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_RR
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave bus
);

  localparam int SEL_W = clog2(N_CH);

  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  ready;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             load;
  logic             accept;

  stream_mux_rr_arbiter #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_arbiter (
    .req   (bus.in_valid),
    .last  (last),
    .grant (grant)
  );

  // The output register may take a new beat when it is empty or being drained
  // this cycle. Ready is forced low during reset so no producer sees a
  // handshake that the register is about to discard.
  assign load   = ~valid_q | bus.out_ready;
  assign ready  = (rst || !load) ? '0 : grant;
  assign accept = |(bus.in_valid & ready);

  // Grant is one-hot, so the encoder and data select can simply OR in the
  // single matching channel.
  always_comb begin
    grant_idx = '0;
    sel_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        grant_idx = SEL_W'(i);
        sel_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage and round-robin pointer. The pointer only moves on an
  // accepted transfer, so stalls and idle cycles keep the rotation intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last    <= SEL_W'(N_CH - 1);
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= sel_data;
      sel_q   <= grant_idx;
      last    <= grant_idx;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
//   Drives a round-robin instance and a fixed-priority instance side by side
//   and compares both against a behavioural model every cycle.
module tb_stream_mux_rr;
  import stream_mux_rr_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) bus0 ();
  stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) bus1 ();

  stream_mux_rr #(.N_CH(N), .WIDTH(W), .MODE(MODE_RR)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  stream_mux_rr #(.N_CH(N), .WIDTH(W), .MODE(MODE_FIXED)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int asserts = 0;
  int fails   = 0;

  // Reference model state: what each output register should hold.
  int         mode   [2];
  bit         m_valid[2];
  logic [7:0] m_data [2];
  int         m_sel  [2];
  int         m_last [2];
  int         acc0, acc1;

  logic [31:0] dpat;
  logic [3:0]  pv [2];
  logic [31:0] pd [2];
  logic        pr [2];

  // Arbitration rule stated directly: next requesting channel after last
  // (modulo N) for round robin, lowest requesting index for fixed priority.
  function automatic int pickChannel(logic [N-1:0] valid, int last, int md);
    if (md == MODE_FIXED) begin
      for (int i = 0; i < N; i++) if (valid[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (valid[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expReady(int d, logic [3:0] valid, logic rdy);
    int g;
    if (rst) return 4'b0;
    g = pickChannel(valid, m_last[d], mode[d]);
    if ((!m_valid[d] || rdy) && g >= 0) return 4'(1 << g);
    return 4'b0;
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 8'h00;
      m_sel[d]   = 0;
      m_last[d]  = N - 1;
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    asserts++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic [3:0] v0, logic [31:0] d0, logic r0,
                               logic [3:0] v1, logic [31:0] d1, logic r1);
    bus0.in_valid  = v0;
    bus0.in_data   = d0;
    bus0.out_ready = r0;
    bus1.in_valid  = v1;
    bus1.in_data   = d1;
    bus1.out_ready = r1;
  endtask

  task automatic checkOne(int d, string name, logic [3:0] valid, logic rdy,
                          logic [3:0] ready, logic ov, logic [7:0] od, logic [1:0] os);
    checkOutput({name, ".in_ready"},  32'(ready), 32'(expReady(d, valid, rdy)));
    checkOutput({name, ".out_valid"}, 32'(ov),    32'(m_valid[d]));
    checkOutput({name, ".out_data"},  32'(od),    32'(m_data[d]));
    checkOutput({name, ".out_sel"},   32'(os),    32'(m_sel[d]));
  endtask

  task automatic advanceOne(int d, logic [3:0] valid, logic rdy, logic [31:0] data,
                            output int acc);
    int g;
    acc = -1;
    if (rst) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 8'h00;
      m_sel[d]   = 0;
      m_last[d]  = N - 1;
      return;
    end
    g = pickChannel(valid, m_last[d], mode[d]);
    if ((!m_valid[d] || rdy) && g >= 0) begin
      acc        = g;
      m_valid[d] = 1'b1;
      m_data[d]  = data[g*W +: W];
      m_sel[d]   = g;
      m_last[d]  = g;
    end else if (rdy) begin
      m_valid[d] = 1'b0;
    end
  endtask

  // One clock: check both DUTs at the falling edge, advance the model on the
  // rising edge, and return just after it so new inputs can be driven.
  task automatic tick();
    @(negedge clk);
    checkOne(0, "rr", bus0.in_valid, bus0.out_ready, bus0.in_ready,
             bus0.out_valid, bus0.out_data, bus0.out_sel);
    checkOne(1, "fixed", bus1.in_valid, bus1.out_ready, bus1.in_ready,
             bus1.out_valid, bus1.out_data, bus1.out_sel);
    @(posedge clk);
    advanceOne(0, bus0.in_valid, bus0.out_ready, bus0.in_data, acc0);
    advanceOne(1, bus1.in_valid, bus1.out_ready, bus1.in_data, acc1);
    #1;
  endtask

  initial begin
    mode[0] = MODE_RR;
    mode[1] = MODE_FIXED;
    dpat    = 32'hA3A2A1A0;

    // Reset with every channel requesting: ready must stay low.
    rst = 1'b1;
    resetModel();
    applyStimulus(4'hF, dpat, 1'b1, 4'hF, dpat, 1'b1);
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Round-robin rotation with all channels valid.
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rot.sel",  32'(bus0.out_sel),  32'(k % 4));
      checkOutput("rot.data", 32'(bus0.out_data), 32'(8'hA0 + (k % 4)));
      checkOutput("fixed.rot.sel", 32'(bus1.out_sel), 32'd0);
    end

    // Back-pressure for three cycles while a beat is held.
    applyStimulus(4'hF, dpat, 1'b0, 4'hF, dpat, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall.sel",      32'(bus0.out_sel),  32'd0);
      checkOutput("stall.data",     32'(bus0.out_data), 32'hA0);
      checkOutput("stall.in_ready", 32'(bus0.in_ready), 32'd0);
    end
    applyStimulus(4'hF, dpat, 1'b1, 4'hF, dpat, 1'b1);
    tick();
    checkOutput("release.sel", 32'(bus0.out_sel), 32'd1);
    tick();
    checkOutput("release.sel2", 32'(bus0.out_sel), 32'd2);

    // Reset asserted mid-stream clears the output in the same cycle.
    rst = 1'b1;
    #1;
    checkOutput("rst.out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rst.out_data",  32'(bus0.out_data),  32'd0);
    checkOutput("rst.out_sel",   32'(bus0.out_sel),   32'd0);
    checkOutput("rst.in_ready",  32'(bus0.in_ready),  32'd0);
    resetModel();
    tick();
    rst = 1'b0;

    // Sparse requests on channels 1 and 3 from the reset pointer.
    applyStimulus(4'b1010, dpat, 1'b1, 4'b1010, dpat, 1'b1);
    tick();
    checkOutput("sparse.sel0", 32'(bus0.out_sel), 32'd1);
    tick();
    checkOutput("sparse.sel1", 32'(bus0.out_sel), 32'd3);
    tick();
    checkOutput("sparse.sel2", 32'(bus0.out_sel), 32'd1);

    // Single isolated beat on channel 2.
    applyStimulus(4'b0000, dpat, 1'b1, 4'b0000, dpat, 1'b1);
    tick();
    applyStimulus(4'b0100, dpat, 1'b1, 4'b0100, dpat, 1'b1);
    tick();
    checkOutput("idle.valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("idle.sel",   32'(bus0.out_sel),   32'd2);
    applyStimulus(4'b0000, dpat, 1'b1, 4'b0000, dpat, 1'b1);
    tick();
    checkOutput("idle.drop", 32'(bus0.out_valid), 32'd0);
    tick();

    // Fixed priority: channel 0 starves channel 2 until it drops.
    applyStimulus(4'b0101, dpat, 1'b1, 4'b0101, dpat, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("fixed.sel0", 32'(bus1.out_sel), 32'd0);
    end
    applyStimulus(4'b0100, dpat, 1'b1, 4'b0100, dpat, 1'b1);
    tick();
    checkOutput("fixed.sel2", 32'(bus1.out_sel), 32'd2);
    checkOutput("fixed.data2", 32'(bus1.out_data), 32'hA2);

    // Randomised traffic: producers hold a beat until it is accepted.
    for (int d = 0; d < 2; d++) begin
      pv[d] = 4'b0;
      pd[d] = 32'b0;
      pr[d] = 1'b1;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc0 == i || !pv[0][i]) begin
          pv[0][i]     = ($urandom_range(0, 9) < 6);
          pd[0][i*W +: W] = 8'($urandom);
        end
        if (acc1 == i || !pv[1][i]) begin
          pv[1][i]     = ($urandom_range(0, 9) < 6);
          pd[1][i*W +: W] = 8'($urandom);
        end
      end
      pr[0] = ($urandom_range(0, 3) != 0);
      pr[1] = ($urandom_range(0, 3) != 0);
      applyStimulus(pv[0], pd[0], pr[0], pv[1], pd[1], pr[1]);
      if (c == 200) begin
        rst = 1'b1;
        resetModel();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
